branch_redirect_ctrl: RTL and testbench
=======================================

Name: branch_redirect_ctrl

Overview:
- Sequences PC redirection for the MIPS pipeline.
- Samples the branch/jump resolution of the instruction in EX (and a jump in ID), then drives the PC-source select and target for exactly one PC-write slot.
- Flushes the wrong-path instructions in IF/ID and ID/EX for a programmable number of cycles.
- Keeps a saturating count of taken redirects for debug.

Parameters:
- NBITS, 32, width of PC and target addresses.
- FLUSH_CYCLES, 2, cycles the flush outputs stay asserted after a redirect (1..7).
- CNT_BITS, 16, width of the taken-redirect counter.

Ports:
- i_clk  in  1  system clock, all state on rising edge.
- i_reset_n  in  1  asynchronous active-low reset.
- i_ex_valid  in  1  EX stage holds a valid instruction.
- i_Branch  in  1  EX instruction is BEQ.
- i_NBranch  in  1  EX instruction is BNE.
- i_cero  in  1  ALU zero flag of the EX instruction.
- i_branch_target  in  NBITS  branch target computed in EX.
- i_id_jump  in  1  ID stage holds a valid J/JAL/JR.
- i_jump_target  in  NBITS  jump target from ID.
- i_stall  in  1  hazard unit freezes PC and IF/ID this cycle.
- o_pcSrc  out  2  PC mux select: 00 PC+4, 01 branch target, 10 jump target.
- o_pc_target  out  NBITS  registered redirect target.
- o_flush_ifid  out  1  zero the IF/ID register.
- o_flush_idex  out  1  zero the ID/EX register.
- o_busy  out  1  high whenever state != IDLE.
- o_taken_count  out  CNT_BITS  saturating count of completed redirects.

Behaviour:
- Reset (async, i_reset_n=0): state=IDLE, o_pcSrc=00, o_pc_target=0, both flushes=0, o_busy=0, o_taken_count=0, flush counter=0.
- take_br = i_ex_valid & ((i_Branch & i_cero) | (i_NBranch & ~i_cero)).
- take_j = i_id_jump.
- IDLE:
  - Events are sampled only when i_stall=0.
  - If take_br: latch i_branch_target, sel=01, go to REDIRECT. take_br wins over a simultaneous take_j because the EX instruction is older; that jump is on the wrong path and gets flushed.
  - Else if take_j: latch i_jump_target, sel=10, go to REDIRECT.
  - With i_stall=1, nothing is latched; the decision is re-evaluated next cycle.
- REDIRECT:
  - o_pcSrc=sel and o_pc_target=latched target.
  - o_flush_ifid=1. o_flush_idex=1 only for a branch redirect; a jump flushes IF/ID only.
  - If i_stall=1: hold all outputs and stay in REDIRECT until the stall drops.
  - If i_stall=0: PC loads the target this edge, o_taken_count increments (saturating at all-ones), flush counter loads FLUSH_CYCLES-1.
    - Next state is FLUSH if FLUSH_CYCLES>1, else IDLE.
- FLUSH:
  - o_pcSrc=00, flush outputs keep the REDIRECT pattern.
  - Counter decrements each cycle with i_stall=0 and holds during a stall; at 0 the next state is IDLE.
  - Branch/jump inputs are ignored because they belong to flushed instructions.
- Latency:
  - Event sampled at edge N; redirect outputs are valid during cycle N+1.
  - Earliest PC load is edge N+1; flushes stay asserted for FLUSH_CYCLES unstalled cycles.
- o_busy = (state != IDLE).
- Outputs are registered; there is no combinational path from inputs to o_pcSrc/flushes.
- Reset asserted mid-REDIRECT/FLUSH aborts immediately to reset values; the pending redirect is lost and the counter is not incremented.
- i_Branch and i_NBranch both high is illegal; resolve by the formula above (OR).

Decomposition:
- Shared package mips_ctrl_pkg:
  - PC-source encodings PCSRC_SEQ=2'b00, PCSRC_BR=2'b01, PCSRC_JMP=2'b10.
  - State enum IDLE/REDIRECT/FLUSH.
- One sub-module is natural: branch_decide, the combinational take_br evaluation, reusable by the hazard unit.
- Counter and FSM stay in the top.

Test Plan:
1. Reset then BEQ in EX with i_cero=1, target 0x0000_0040, FLUSH_CYCLES=2, no stall -> next cycle o_pcSrc=01, o_pc_target=0x40, both flushes high for 2 cycles, then IDLE, o_taken_count=1.
2. BNE with i_cero=1, then BNE with i_cero=0, target 0x80 -> the first causes no redirect (o_pcSrc stays 00); the second redirects to 0x80.
3. Jump in ID to 0x100 and taken BEQ to 0x200 in the same cycle -> branch wins: o_pcSrc=01, target 0x200, o_flush_idex=1.
4. Taken branch then i_stall=1 for 3 cycles in REDIRECT -> outputs held 3 cycles; count increments only after the stall drops; flush window is still 2 unstalled cycles.
5. Lone jump to 0x3FC -> o_pcSrc=10, o_flush_ifid=1, o_flush_idex=0, count+1.
6. i_reset_n pulsed low during FLUSH, plus a saturation run with CNT_BITS=2 -> immediate reset values; after 5 redirects o_taken_count stays 3.

Source files
------------

// File: rtl/mips_ctrl_pkg.sv
// Shared MIPS pipeline control definitions: PC-source encodings and the
// redirect sequencer state type.
package mips_ctrl_pkg;

    localparam logic [1:0] PCSRC_SEQ = 2'b00;
    localparam logic [1:0] PCSRC_BR  = 2'b01;
    localparam logic [1:0] PCSRC_JMP = 2'b10;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        REDIRECT = 2'd1,
        FLUSH    = 2'd2
    } state_t;

endpackage

// File: rtl/branch_decide.sv
// Combinational taken-branch evaluation for the instruction in EX
// (BEQ taken on zero, BNE taken on non-zero). Shared with the hazard unit.
module branch_decide (
    input  logic i_ex_valid,
    input  logic i_Branch,
    input  logic i_NBranch,
    input  logic i_cero,
    output logic o_take_br
);

    // Both opcode flags high is illegal upstream; the OR simply merges them.
    assign o_take_br = i_ex_valid & ((i_Branch & i_cero) | (i_NBranch & ~i_cero));

endmodule

// File: rtl/branch_redirect_ctrl.sv
// PC redirect sequencer: latches a taken branch (EX) or jump (ID), drives the
// PC-source select for one PC-write slot, then holds the wrong-path flushes.
module branch_redirect_ctrl
    import mips_ctrl_pkg::*;
#(
    parameter int NBITS        = 32,
    parameter int FLUSH_CYCLES = 2,
    parameter int CNT_BITS     = 16
) (
    input  logic                i_clk,
    input  logic                i_reset_n,
    input  logic                i_ex_valid,
    input  logic                i_Branch,
    input  logic                i_NBranch,
    input  logic                i_cero,
    input  logic [NBITS-1:0]    i_branch_target,
    input  logic                i_id_jump,
    input  logic [NBITS-1:0]    i_jump_target,
    input  logic                i_stall,
    output logic [1:0]          o_pcSrc,
    output logic [NBITS-1:0]    o_pc_target,
    output logic                o_flush_ifid,
    output logic                o_flush_idex,
    output logic                o_busy,
    output logic [CNT_BITS-1:0] o_taken_count,
    output state_t              o_dbg_state
);

    localparam logic [2:0]          FLUSH_LOAD = 3'(FLUSH_CYCLES - 1);
    localparam logic [CNT_BITS-1:0] CNT_ONE    = {{(CNT_BITS-1){1'b0}}, 1'b1};

    state_t              state_q, state_d;
    logic [1:0]          sel_q, sel_d;
    logic [NBITS-1:0]    target_q, target_d;
    logic [2:0]          fcnt_q, fcnt_d;
    logic [CNT_BITS-1:0] count_q, count_d;
    logic                take_br;

    branch_decide u_branch_decide (
        .i_ex_valid (i_ex_valid),
        .i_Branch   (i_Branch),
        .i_NBranch  (i_NBranch),
        .i_cero     (i_cero),
        .o_take_br  (take_br)
    );

    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            state_q  <= IDLE;
            sel_q    <= PCSRC_SEQ;
            target_q <= '0;
            fcnt_q   <= '0;
            count_q  <= '0;
        end else begin
            state_q  <= state_d;
            sel_q    <= sel_d;
            target_q <= target_d;
            fcnt_q   <= fcnt_d;
            count_q  <= count_d;
        end
    end

    // i_stall acts as the pipeline's inverted ready: a redirect slot or flush
    // cycle is consumed only on an edge where i_stall is low; otherwise held.
    always_comb begin
        state_d  = state_q;
        sel_d    = sel_q;
        target_d = target_q;
        fcnt_d   = fcnt_q;
        count_d  = count_q;
        case (state_q)
            IDLE: begin
                if (!i_stall) begin
                    if (take_br) begin
                        sel_d    = PCSRC_BR;
                        target_d = i_branch_target;
                        state_d  = REDIRECT;
                    end else if (i_id_jump) begin
                        sel_d    = PCSRC_JMP;
                        target_d = i_jump_target;
                        state_d  = REDIRECT;
                    end
                end
            end
            REDIRECT: begin
                if (!i_stall) begin
                    count_d = (&count_q) ? count_q : count_q + CNT_ONE;
                    fcnt_d  = FLUSH_LOAD;
                    state_d = (FLUSH_CYCLES > 1) ? FLUSH : IDLE;
                end
            end
            FLUSH: begin
                if (!i_stall) begin
                    fcnt_d = fcnt_q - 3'd1;
                    if (fcnt_q <= 3'd1) begin
                        state_d = IDLE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Outputs decode registered state only, so no input reaches them combinationally.
    assign o_pcSrc       = (state_q == REDIRECT) ? sel_q : PCSRC_SEQ;
    assign o_pc_target   = target_q;
    assign o_flush_ifid  = (state_q != IDLE);
    assign o_flush_idex  = (state_q != IDLE) && (sel_q == PCSRC_BR);
    assign o_busy        = (state_q != IDLE);
    assign o_taken_count = count_q;
    assign o_dbg_state   = state_q;

endmodule

// File: tb/tb_branch_redirect_ctrl.sv
// Bench for branch_redirect_ctrl: directed scenarios plus random traffic, checked
// through an expected-output queue filled by a cycle-level reference model.
module tb_branch_redirect_ctrl;
    import mips_ctrl_pkg::*;

    localparam int NBITS = 32;
    localparam int FC    = 2;
    localparam int CB    = 2;
    localparam int W     = 2 + 2 + NBITS + 3 + CB;
    localparam int CMAX  = (1 << CB) - 1;

    // clock / reset
    logic i_clk = 1'b0;
    always #5 i_clk = ~i_clk;

    logic             i_reset_n = 1'b0;
    logic             i_ex_valid = 1'b0, i_Branch = 1'b0, i_NBranch = 1'b0, i_cero = 1'b0;
    logic [NBITS-1:0] i_branch_target = '0, i_jump_target = '0;
    logic             i_id_jump = 1'b0, i_stall = 1'b0;
    logic [1:0]       o_pcSrc;
    logic [NBITS-1:0] o_pc_target;
    logic             o_flush_ifid, o_flush_idex, o_busy;
    logic [CB-1:0]    o_taken_count;
    state_t           o_dbg_state;

    branch_redirect_ctrl #(.NBITS(NBITS), .FLUSH_CYCLES(FC), .CNT_BITS(CB)) dut (
        .i_clk(i_clk), .i_reset_n(i_reset_n), .i_ex_valid(i_ex_valid),
        .i_Branch(i_Branch), .i_NBranch(i_NBranch), .i_cero(i_cero),
        .i_branch_target(i_branch_target), .i_id_jump(i_id_jump),
        .i_jump_target(i_jump_target), .i_stall(i_stall), .o_pcSrc(o_pcSrc),
        .o_pc_target(o_pc_target), .o_flush_ifid(o_flush_ifid),
        .o_flush_idex(o_flush_idex), .o_busy(o_busy),
        .o_taken_count(o_taken_count), .o_dbg_state(o_dbg_state)
    );

    int n_tests = 0;
    int n_fail  = 0;
    logic [W-1:0] exp_q[$];

    // reference model: a redirect is a window of FC unstalled cycles whose
    // first one carries the PC write
    int               m_left;
    bit               m_pending;
    logic [1:0]       m_kind;
    logic [NBITS-1:0] m_tgt;
    int               m_cnt;

    function automatic void model_reset();
        m_left = 0; m_pending = 0; m_kind = PCSRC_SEQ; m_tgt = '0; m_cnt = 0;
    endfunction

    function automatic void model_step();
        bit br_taken;
        if (!i_reset_n) begin
            model_reset();
            return;
        end
        if (m_left > 0) begin
            if (!i_stall) begin
                if (m_pending) begin
                    m_pending = 0;
                    if (m_cnt < CMAX) m_cnt++;
                end
                m_left--;
            end
        end else if (!i_stall) begin
            br_taken = i_ex_valid && ((i_Branch && i_cero) || (i_NBranch && !i_cero));
            if (br_taken) begin
                m_kind = PCSRC_BR; m_tgt = i_branch_target; m_pending = 1; m_left = FC;
            end else if (i_id_jump) begin
                m_kind = PCSRC_JMP; m_tgt = i_jump_target; m_pending = 1; m_left = FC;
            end
        end
    endfunction

    function automatic logic [W-1:0] model_expect();
        bit         busy;
        logic [1:0] st;
        logic [1:0] pcsrc;
        busy  = (m_left > 0);
        st    = !busy ? 2'(IDLE) : (m_pending ? 2'(REDIRECT) : 2'(FLUSH));
        pcsrc = m_pending ? m_kind : PCSRC_SEQ;
        return {st, pcsrc, m_tgt, busy, busy && (m_kind == PCSRC_BR), busy, CB'(m_cnt)};
    endfunction

    // driver: inputs change 1ns after the edge; the model consumes the values
    // that were present at that edge, then the new values are applied
    task automatic drive(input logic rst_n, input logic v, input logic b, input logic nb,
                         input logic z, input logic [NBITS-1:0] bt, input logic j,
                         input logic [NBITS-1:0] jt, input logic s);
        @(posedge i_clk);
        #1;
        model_step();
        i_reset_n = rst_n; i_ex_valid = v; i_Branch = b; i_NBranch = nb; i_cero = z;
        i_branch_target = bt; i_id_jump = j; i_jump_target = jt; i_stall = s;
        if (!rst_n) model_reset();
        exp_q.push_back(model_expect());
    endtask

    task automatic idle(input int n, input logic s = 1'b0);
        for (int k = 0; k < n; k++) drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, '0, 1'b0, '0, s);
    endtask

    task automatic beq(input logic [NBITS-1:0] t);
        drive(1'b1, 1'b1, 1'b1, 1'b0, 1'b1, t, 1'b0, '0, 1'b0);
    endtask

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // monitor: outputs are sampled mid-cycle on the falling edge
    initial begin
        logic [W-1:0] e;
        forever begin
            @(negedge i_clk);
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                check("state",       64'(o_dbg_state),   64'(e[W-1 -: 2]));
                check("pcSrc",       64'(o_pcSrc),       64'(e[W-3 -: 2]));
                check("pc_target",   64'(o_pc_target),   64'(e[W-5 -: NBITS]));
                check("flush_ifid",  64'(o_flush_ifid),  64'(e[CB+2]));
                check("flush_idex",  64'(o_flush_idex),  64'(e[CB+1]));
                check("busy",        64'(o_busy),        64'(e[CB]));
                check("taken_count", 64'(o_taken_count), 64'(e[CB-1:0]));
            end
        end
    end

    initial begin
        model_reset();
        // reset values, then BEQ taken to 0x40
        drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, '0, 1'b0, '0, 1'b0);
        drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, '0, 1'b0, '0, 1'b0);
        idle(1);
        beq(32'h40);
        idle(4);
        // BNE with zero set (not taken) then BNE with zero clear (taken)
        drive(1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 32'h70, 1'b0, '0, 1'b0);
        idle(1);
        drive(1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 32'h80, 1'b0, '0, 1'b0);
        idle(4);
        // simultaneous jump and taken branch: branch wins
        drive(1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 32'h200, 1'b1, 32'h100, 1'b0);
        idle(4);
        // stall held in REDIRECT for three cycles
        beq(32'h44);
        idle(3, 1'b1);
        idle(4);
        // lone jump
        drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, '0, 1'b1, 32'h3FC, 1'b0);
        idle(4);
        // stall in FLUSH, then a stalled event in IDLE is not latched
        beq(32'h48);
        idle(1);
        idle(2, 1'b1);
        idle(2);
        drive(1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 32'h4C, 1'b1, 32'h50, 1'b1);
        idle(2);
        // reset mid-FLUSH and mid-REDIRECT
        beq(32'h60);
        idle(1);
        drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, '0, 1'b0, '0, 1'b0);
        idle(1);
        beq(32'h64);
        drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, '0, 1'b0, '0, 1'b0);
        idle(1);
        // five redirects: 2-bit counter saturates at 3
        for (int r = 0; r < 5; r++) begin
            beq(32'h100 + 32'(r * 4));
            idle(3);
        end
        // random traffic
        for (int c = 0; c < 3000; c++) begin
            drive(($urandom_range(0, 99) != 0),
                  ($urandom_range(0, 3) != 0),
                  1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                  1'($urandom_range(0, 1)),
                  $urandom() & 32'hFFFF_FFFC,
                  ($urandom_range(0, 3) == 0),
                  $urandom() & 32'hFFFF_FFFC,
                  ($urandom_range(0, 3) == 0));
        end
        @(negedge i_clk);
        #1;
        check("queue_drained", 64'(exp_q.size()), 64'd0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
